// File: rtl/imm_extend_pipe_pkg.sv
// Shared immediate-extension constants: mode encodings and branch shift amount.
// Latency: none (constants only).
// Backpressure: not applicable.
package imm_ext_pkg;

    localparam logic [1:0] MODE_SIGN   = 2'd0;
    localparam logic [1:0] MODE_ZERO   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    localparam int BRANCH_SHIFT = 2;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Bundle of handshake, control and data signals between the ID stage and the immediate pipe.
// Latency: none (wires only).
// Backpressure: stall_i holds the pipe; the upstream re-presents the dropped input.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             valid_i;
    logic             stall_i;
    logic             flush_i;
    logic [1:0]       mode_i;
    logic [IN_W-1:0]  data_i;
    logic [OUT_W-1:0] data_o;
    logic             valid_o;
    logic [1:0]       mode_o;

    modport master (
        output valid_i, stall_i, flush_i, mode_i, data_i,
        input  data_o, valid_o, mode_o
    );

    modport slave (
        input  valid_i, stall_i, flush_i, mode_i, data_i,
        output data_o, valid_o, mode_o
    );
endinterface

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extender: sign, zero, upper and branch-offset modes.
// Latency: 0 cycles.
// Backpressure: none; purely combinational.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] uext;

    assign sext = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
    assign zext = {{(OUT_W-IN_W){1'b0}}, data};
    assign uext = {data, {(OUT_W-IN_W){1'b0}}};

    // Branch offsets are word-aligned: the top BRANCH_SHIFT bits fall off the sign-extended value.
    always_comb begin
        ext = sext;
        case (mode)
            MODE_SIGN:   ext = sext;
            MODE_ZERO:   ext = zext;
            MODE_UPPER:  ext = uext;
            MODE_BRANCH: ext = sext << BRANCH_SHIFT;
            default:     ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: extends data_i then carries {valid, mode, result} through STAGES registers.
// Latency: STAGES cycles from input sample to valid_o, all outputs registered.
// Backpressure: stall_i freezes every stage and drops the input; flush_i empties the pipe and wins over stall.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    imm_extend_pipe_if.slave bus
);

    typedef struct packed {
        logic             vld;
        logic [1:0]       mode;
        logic [OUT_W-1:0] dat;
    } stage_t;

    stage_t           pipe [STAGES];
    logic [OUT_W-1:0] ext_dat;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode (bus.mode_i),
        .data (bus.data_i),
        .ext  (ext_dat)
    );

    // Flush is checked before stall so a stalled pipe can still be emptied.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else if (bus.flush_i) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else if (!bus.stall_i) begin
            pipe[0].vld  <= bus.valid_i;
            pipe[0].mode <= bus.mode_i;
            pipe[0].dat  <= ext_dat;
            for (int k = 1; k < STAGES; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign bus.valid_o = pipe[STAGES-1].vld;
    assign bus.mode_o  = pipe[STAGES-1].mode;
    assign bus.data_o  = pipe[STAGES-1].dat;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-generation unit for the pipelined CPU's ID/EX path.
- Extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI), and branch offset (sign-extend then shift left 2).
- Results travel through STAGES register stages with a valid bit, so the block obeys the pipeline's stall and flush controls.

Parameters:
- IN_W, 16, immediate input width; legal range 1..OUT_W-2.
- OUT_W, 32, extended output width.
- STAGES, 1, register stages between input and output; legal range 1..4.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  input immediate valid this cycle.
- stall_i  input  1  hold all stages; the input is not captured.
- flush_i  input  1  kill all in-flight entries.
- mode_i  input  2  extension mode: 0 SIGN, 1 ZERO, 2 UPPER, 3 BRANCH.
- data_i  input  IN_W  raw immediate.
- data_o  output  OUT_W  extended result from the last stage.
- valid_o  output  1  data_o valid.
- mode_o  output  2  mode carried alongside the result.

Behaviour:
- Extension is combinational at the input, computed before stage 0:
  - SIGN: {(OUT_W-IN_W){data_i[IN_W-1]}, data_i}.
  - ZERO: {(OUT_W-IN_W){1'b0}, data_i}.
  - UPPER: data_i placed in the top IN_W bits, low OUT_W-IN_W bits zero.
  - BRANCH: the SIGN result shifted left by 2; the top 2 bits are discarded and the low 2 bits are zero.
- Pipeline: STAGES entries, each holding {valid, mode, result}.
  - Stage 0 captures {valid_i, mode_i, ext(data_i)}.
  - Stage k captures stage k-1.
  - Outputs come from stage STAGES-1.
- Latency: exactly STAGES cycles from a valid_i sample to valid_o, with no stall or flush in between.
- Throughput: one result per cycle.
- valid_i=0: stage 0 captures valid=0. Its data field still updates (don't-care), but verification checks data_o only when valid_o=1.
- stall_i=1: every stage, including its valid bit, holds its value. The valid_i/data_i presented that cycle are dropped; upstream holds and re-presents them.
- flush_i=1: on the next edge every stage loads valid=0, mode=0, result=0.
  - flush_i overrides stall_i and valid_i.
  - Output after flush: valid_o=0, data_o=0.
- Flush and stall together: the flush is applied and the pipeline is empty on the next cycle.
- Reset (rst_i=1, asynchronous): every stage is cleared immediately, without waiting for a clock edge. Outputs become valid_o=0, data_o=0, mode_o=0.
  - Reset asserted mid-operation discards all in-flight entries.
  - The first capture after deassertion happens on the first rising edge with rst_i=0.
- No combinational path from any input to any output. All outputs are registered.
- Mode encodings outside 0..3 cannot occur (2-bit field).

Decomposition:
- Shared package imm_ext_pkg:
  - Mode constants MODE_SIGN=2'd0, MODE_ZERO=2'd1, MODE_UPPER=2'd2, MODE_BRANCH=2'd3.
  - BRANCH_SHIFT=2.
  - The same mode constants are used by the decoder and control unit.
- Sub-module imm_ext_core: purely combinational, parametrised by IN_W/OUT_W, inputs mode and data, output extended value.
- The top level holds the STAGES-deep register array and the stall/flush/reset logic.

Test Plan:
- SIGN, zero-extension, STAGES=1: valid_i=1 with data_i=16'h8000 in mode SIGN, then 16'h8000 in mode ZERO on the next cycle.
  - Required: the cycle after each sample, valid_o=1 and data_o=32'hFFFF8000, then 32'h00008000, with mode_o matching.
- UPPER and BRANCH:
  - data_i=16'h1234 in mode UPPER gives 32'h12340000.
  - data_i=16'hFFFF in mode BRANCH gives 32'hFFFFFFFC.
  - data_i=16'h0003 in mode BRANCH gives 32'h0000000C.
- Latency and throughput, STAGES=3: back-to-back valid inputs 16'h0001, 0002, 0003 in mode SIGN.
  - Required: valid_o rises exactly 3 cycles after the first input.
  - data_o shows 1, 2, 3 on consecutive cycles.
- Stall, STAGES=2: apply 16'h0005 then 16'h0006 on consecutive cycles, then hold stall_i=1 for 2 cycles while presenting 16'h0007.
  - Required: data_o stays 32'h00000005 with valid_o=1 for both stall cycles.
  - 16'h0007 never appears at the output.
- Flush: fill STAGES=3 with valid entries, then assert flush_i and stall_i together for 1 cycle.
  - Required: the next cycle valid_o=0 and data_o=0, and no pre-flush entry ever appears afterwards.
- Asynchronous reset: with valid_o=1, assert rst_i between clock edges.
  - Required: valid_o=0 and data_o=0 before the next rising edge.
  - After deassertion, input 16'h7FFF in mode SIGN gives 32'h00007FFF after STAGES cycles.
